// File: rtl/invaes_pkg.sv
// Shared types and sizes for the inverse-AES SPI master.
package invaes_pkg;

   localparam int BLOCK_BITS = 128;
   localparam int LOAD_BITS  = 256;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT,
      READ,
      FIN
   } spi_state_t;

endpackage

// File: rtl/invaes_spi_master_if.sv
// Host-side handshake and SPI pins of the inverse-AES SPI master.
interface invaes_spi_master_if;
   import invaes_pkg::*;

   logic                  start;
   logic [BLOCK_BITS-1:0] key;
   logic [BLOCK_BITS-1:0] plaintext;
   logic                  busy;
   logic                  valid;
   logic [BLOCK_BITS-1:0] cyphertext;
   logic                  sclk;
   logic                  mosi;
   logic                  load;
   logic                  miso;
   logic                  done;

   modport master (
      input  start, key, plaintext, miso, done,
      output busy, valid, cyphertext, sclk, mosi, load
   );

   modport slave (
      output start, key, plaintext, miso, done,
      input  busy, valid, cyphertext, sclk, mosi, load
   );

endinterface

// File: rtl/spi_clkgen.sv
// CLKDIV divider producing a mode-0 sclk plus single-cycle rise/fall strobes.
module spi_clkgen #(
   parameter int CLKDIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);

   logic [7:0] div_cnt_reg;
   logic       sclk_reg;
   logic       term;

   assign term = en && (div_cnt_reg == 8'(CLKDIV - 1));

   // Disabling parks sclk low and restarts the count so the next enable
   // gives a full half-period before the first rise.
   always_ff @(posedge clk) begin
      if (reset || !en) begin
         div_cnt_reg <= 8'd0;
         sclk_reg    <= 1'b0;
      end else if (term) begin
         div_cnt_reg <= 8'd0;
         sclk_reg    <= ~sclk_reg;
      end else begin
         div_cnt_reg <= div_cnt_reg + 8'd1;
      end
   end

   assign sclk = sclk_reg;
   assign rise = term && !sclk_reg;
   assign fall = term && sclk_reg;

endmodule

// File: rtl/invaes_spi_master.sv
// SPI master: shifts {plaintext, key} out under load, waits for done,
// then reads the 128-bit result back and strobes valid.
module invaes_spi_master
   import invaes_pkg::*;
#(
   parameter int CLKDIV = 4
) (
   input logic                 clk,
   input logic                 reset,
   invaes_spi_master_if.master bus
);

   spi_state_t            state_reg, state_next;
   logic [LOAD_BITS-1:0]  tx_reg;
   logic [BLOCK_BITS-1:0] rx_reg;
   logic [BLOCK_BITS-1:0] cyphertext_reg;
   logic                  load_reg;
   logic [8:0]            bit_cnt_reg;
   logic [7:0]            settle_cnt_reg;

   logic                  clk_en;
   logic                  sclk_int;
   logic                  rise;
   logic                  fall;

   logic [1:0]            sync_in;
   logic [1:0]            sync_out;
   logic                  miso_s;
   logic                  done_s;
   logic                  settling;

   // Two-flop synchronizers: bit 0 = miso, bit 1 = done.
   assign sync_in = {bus.done, bus.miso};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         logic meta_reg;
         logic out_reg;
         always_ff @(posedge clk) begin
            if (reset) begin
               meta_reg <= 1'b0;
               out_reg  <= 1'b0;
            end else begin
               meta_reg <= sync_in[gi];
               out_reg  <= meta_reg;
            end
         end
         assign sync_out[gi] = out_reg;
      end
   endgenerate

   assign miso_s = sync_out[0];
   assign done_s = sync_out[1];

   assign clk_en = (state_reg == LOAD) || (state_reg == READ);

   spi_clkgen #(
      .CLKDIV (CLKDIV)
   ) u_clkgen (
      .clk   (clk),
      .reset (reset),
      .en    (clk_en),
      .sclk  (sclk_int),
      .rise  (rise),
      .fall  (fall)
   );

   // Once done has been seen the settle count runs to completion on its own.
   assign settling = done_s || (settle_cnt_reg != 8'd0);

   always_comb begin
      state_next = state_reg;
      bus.busy   = (state_reg != IDLE);
      bus.valid  = (state_reg == FIN);
      case (state_reg)
         IDLE: if (bus.start) state_next = LOAD;
         LOAD: if (fall && bit_cnt_reg == 9'(LOAD_BITS)) state_next = WAIT;
         WAIT: if (settling && settle_cnt_reg == 8'(CLKDIV - 1)) state_next = READ;
         READ: if (fall && bit_cnt_reg == 9'(BLOCK_BITS)) state_next = FIN;
         FIN:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         tx_reg         <= '0;
         rx_reg         <= '0;
         cyphertext_reg <= '0;
         load_reg       <= 1'b0;
         bit_cnt_reg    <= 9'd0;
         settle_cnt_reg <= 8'd0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  tx_reg         <= {bus.plaintext, bus.key};
                  load_reg       <= 1'b1;
                  bit_cnt_reg    <= 9'd0;
                  settle_cnt_reg <= 8'd0;
               end
            end
            LOAD: begin
               if (rise && bit_cnt_reg != 9'(LOAD_BITS))
                  bit_cnt_reg <= bit_cnt_reg + 9'd1;
               // Zeros shift in behind the frame, so mosi is already 0
               // when the final fall closes the load window.
               if (fall) begin
                  tx_reg <= tx_reg << 1;
                  if (bit_cnt_reg == 9'(LOAD_BITS)) begin
                     load_reg    <= 1'b0;
                     bit_cnt_reg <= 9'd0;
                  end
               end
            end
            WAIT: begin
               if (settling) begin
                  if (settle_cnt_reg == 8'(CLKDIV - 1))
                     settle_cnt_reg <= 8'd0;
                  else
                     settle_cnt_reg <= settle_cnt_reg + 8'd1;
               end
            end
            READ: begin
               if (rise) begin
                  rx_reg <= {rx_reg[BLOCK_BITS-2:0], miso_s};
                  if (bit_cnt_reg != 9'(LOAD_BITS))
                     bit_cnt_reg <= bit_cnt_reg + 9'd1;
               end
               if (fall && bit_cnt_reg == 9'(BLOCK_BITS)) begin
                  cyphertext_reg <= rx_reg;
                  bit_cnt_reg    <= 9'd0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sclk       = sclk_int;
   assign bus.mosi       = tx_reg[LOAD_BITS-1];
   assign bus.load       = load_reg;
   assign bus.cyphertext = cyphertext_reg;

endmodule

// File: tb/tb_invaes_spi_master.sv
// Directed bench with a behavioural SPI slave and a valid-driven scoreboard.
module tb_invaes_spi_master;

   logic clk = 1'b0;
   logic reset;
   logic rst6;

   always #5 clk = ~clk;

   invaes_spi_master_if bus ();
   invaes_spi_master_if bus6 ();

   invaes_spi_master #(.CLKDIV(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   invaes_spi_master #(.CLKDIV(6)) dut6 (
      .clk   (clk),
      .reset (rst6),
      .bus   (bus6.master)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural slave ----------------
   logic [255:0] exp_frame;
   logic [255:0] rx_frame;
   logic [127:0] slave_result;
   logic [127:0] tx_shift;
   int           done_delay;
   int           bits_rx;
   int           wait_edges;
   int           done_timer;
   int           rd_bits;
   int           first_cnt;
   bit           waiting;
   bit           reading;
   bit           abort;
   logic         load_q, sclk_q, mosi_q;

   initial begin
      bus.miso = 1'b0;
      bus.done = 1'b0;
      load_q = 1'b0; sclk_q = 1'b0; mosi_q = 1'b0;
      waiting = 0; reading = 0; abort = 0;
      bits_rx = 0; rx_frame = '0;
      forever begin
         @(posedge clk);
         #2;
         if (bus.mosi !== mosi_q && !(bus.load && !load_q) && !abort && reset !== 1'b1)
            check("mosi_on_fall", {sclk_q, bus.sclk}, 2'b10);
         if (bus.load && !load_q) begin
            bits_rx = 0; rx_frame = '0;
            bus.done = 1'b0; bus.miso = 1'b0;
            waiting = 0; reading = 0;
         end
         if (bus.load && bus.sclk && !sclk_q) begin
            rx_frame = {rx_frame[254:0], bus.mosi};
            bits_rx++;
         end
         if (!bus.load && load_q) begin
            if (abort) begin
               abort = 0;
            end else begin
               check("load_rises", bits_rx, 256);
               check("load_frame", rx_frame, exp_frame);
               waiting = 1; done_timer = done_delay; wait_edges = 0;
            end
         end else if (waiting) begin
            if (bus.sclk !== sclk_q) wait_edges++;
            if (done_timer == 0) begin
               check("wait_no_sclk", wait_edges, 0);
               bus.done = 1'b1;
               tx_shift = slave_result;
               bus.miso = tx_shift[127];
               waiting = 0; reading = 1; rd_bits = 0; first_cnt = 0;
            end else begin
               done_timer--;
            end
         end else if (reading) begin
            first_cnt++;
            if (bus.sclk && !sclk_q) begin
               rd_bits++;
               if (rd_bits == 1) check("done_to_rise", first_cnt, 2 + 2 * 4);
            end
            if (!bus.sclk && sclk_q) begin
               tx_shift = tx_shift << 1;
               bus.miso = tx_shift[127];
               if (rd_bits == 128) reading = 0;
            end
         end
         load_q = bus.load; sclk_q = bus.sclk; mosi_q = bus.mosi;
      end
   end

   // ---------------- scoreboard monitor ----------------
   logic [127:0] exp_q[$];
   logic [127:0] exp_val;
   int           valid_cnt = 0;
   bit           prev_valid = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (prev_valid) begin
            check("valid_one_cycle", bus.valid, 1'b0);
            check("busy_after_valid", bus.busy, 1'b0);
         end
         if (bus.valid === 1'b1) begin
            valid_cnt++;
            check("busy_in_valid", bus.busy, 1'b1);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_valid: got %0h, expected no valid", bus.cyphertext);
            end else begin
               exp_val = exp_q.pop_front();
               check("cyphertext", bus.cyphertext, exp_val);
            end
         end
         prev_valid = (bus.valid === 1'b1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_txn(input logic [127:0] pt, input logic [127:0] k,
                          input logic [127:0] res, input int delay, input bit pulse_starts);
      int v0;
      int cyc;
      exp_frame    = {pt, k};
      slave_result = res;
      done_delay   = delay;
      v0 = valid_cnt;
      @(posedge clk); #1;
      bus.plaintext = pt;
      bus.key       = k;
      bus.start     = 1'b1;
      exp_q.push_back(res);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_after_start", bus.busy, 1'b1);
      check("load_after_start", bus.load, 1'b1);
      check("mosi_first_bit", bus.mosi, pt[127]);
      if (pulse_starts) begin
         repeat (20) @(posedge clk);
         #1;
         bus.key = ~k; bus.plaintext = ~pt; bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
         cyc = 0;
         while (bus.load && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
         end
         check("load_end_timeout", cyc < 5000, 1'b1);
         repeat (100) @(posedge clk);
         #1;
         bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      cyc = 0;
      while (valid_cnt == v0 && cyc < 20000) begin
         @(posedge clk);
         cyc++;
      end
      check("valid_timeout", cyc < 20000, 1'b1);
      repeat (pulse_starts ? 4000 : 3) @(posedge clk);
      check("valid_count", valid_cnt - v0, 1);
   endtask

   initial begin
      int cnt;
      int len;
      logic cur;
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int len;
      logic cur;
      reset = 1'b1; rst6 = 1'b1;
      bus.start = 1'b0; bus.key = '0; bus.plaintext = '0;
      bus6.start = 1'b0; bus6.key = 128'h0f0e; bus6.plaintext = 128'h1234;
      bus6.miso = 1'b0; bus6.done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sclk", bus.sclk, 1'b0);
      check("rst_mosi", bus.mosi, 1'b0);
      check("rst_load", bus.load, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_valid", bus.valid, 1'b0);
      check("rst_cyphertext", bus.cyphertext, 128'h0);
      reset = 1'b0; rst6 = 1'b0;

      // FIPS-197 inverse cipher vector
      run_txn(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff, 50, 0);
      // load bit order: only first and last bits set
      run_txn(128'h80000000000000000000000000000000, 128'h00000000000000000000000000000001,
              128'hdeadbeef0123456789abcdef55aa33cc, 50, 0);
      // read bit order
      run_txn(128'h0123456789abcdeffedcba9876543210, 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0,
              128'h80000000000000000000000000000001, 50, 0);
      // long wait with ignored starts
      run_txn(128'hcafef00d000000001111111122222222, 128'h33333333444444445555555566666666,
              128'h7777777788888888999999990badc0de, 5000, 1);

      // reset after the 100th rise of a load frame
      exp_frame = {128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f};
      @(posedge clk); #1;
      bus.plaintext = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      bus.key       = 128'h000102030405060708090a0b0c0d0e0f;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cnt = 0;
      while (bits_rx < 100 && cnt < 3000) begin
         @(posedge clk); #3;
         cnt++;
      end
      check("rise100_timeout", cnt < 3000, 1'b1);
      abort = 1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrst_sclk", bus.sclk, 1'b0);
      check("midrst_load", bus.load, 1'b0);
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_mosi", bus.mosi, 1'b0);
      reset = 1'b0;
      run_txn(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff, 50, 0);

      // sclk shape at CLKDIV=6
      @(posedge clk); #1;
      bus6.start = 1'b1;
      cnt = 0;
      while (cnt < 100) begin
         @(posedge clk);
         cnt++;
         #1;
         if (cnt == 1) bus6.start = 1'b0;
         if (bus6.sclk) break;
      end
      check("div6_first_rise_edge", cnt, 7);
      for (int p = 0; p < 8; p++) begin
         len = 0;
         cur = bus6.sclk;
         do begin
            @(posedge clk); #1;
            len++;
         end while (bus6.sclk == cur && len < 50);
         check("div6_phase_len", len, 6);
      end
      rst6 = 1'b1;
      @(posedge clk); #1;
      check("div6_rst_sclk", bus6.sclk, 1'b0);
      rst6 = 1'b0;

      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/invaes_spi_master.md
# invaes_spi_master

SPI master that drives the inverse-AES accelerator's SPI slave port from the system clock domain. It shifts the 256-bit `{plaintext, key}` load frame out with `load` asserted, then releases `load` and waits for `done`. It then clocks the 128-bit `cyphertext` result back in and presents it with a one-cycle `valid` strobe. It sits in the host-side/test-harness logic and is the initiating end of the accelerator's SPI protocol.

## Interface
- `CLKDIV`, default 4: `clk` cycles per `sclk` half-period; legal range ≥ 4.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  begin a transaction; sampled only in IDLE.
- `key`  input  128  key, captured on the accepted `start`.
- `plaintext`  input  128  block to decrypt, captured on the accepted `start`.
- `busy`  output  1  high from the cycle after an accepted `start` through the `valid` cycle.
- `valid`  output  1  one-cycle strobe; `cyphertext` is updated in the same cycle.
- `cyphertext`  output  128  result block; holds its value until the next `valid`.
- `sclk`  output  1  SPI clock; idles low (mode 0).
- `mosi`  output  1  serial data to the slave; MSB-first.
- `load`  output  1  high for the whole load frame.
- `miso`  input  1  serial data from the slave; passes through a 2-flop synchronizer.
- `done`  input  1  accelerator done; passes through a 2-flop synchronizer.

## Operation
- Reset values: `sclk`=0, `mosi`=0, `load`=0, `busy`=0, `valid`=0, `cyphertext`=0. The FSM enters IDLE and all counters clear.
- FSM states and transitions:
  - IDLE → LOAD on `start`. On that edge the 256-bit shift register captures `{plaintext, key}`, `mosi` is set to `plaintext[127]` and `load` is set to 1.
  - LOAD: generates 256 `sclk` periods. On each falling `sclk` toggle the register shifts left and `mosi` takes the next bit. Bit order is `plaintext[127]` first through `key[0]` last.
  - LOAD → WAIT on the falling toggle after the 256th rising edge. In that cycle `load`=0, `mosi`=0 and `sclk`=0.
  - WAIT: no `sclk` edges. When synchronized `done`=1, the block waits CLKDIV cycles so the slave's first `miso` bit can settle, then moves to READ.
  - READ: generates 128 `sclk` periods. At each rising toggle the synchronized `miso` is shifted into the LSB of the receive register. The first bit sampled is `cyphertext[127]`.
  - READ → FIN on the falling toggle after the 128th rising edge.
  - FIN: `cyphertext` is loaded from the receive register and `valid`=1 for one cycle. Next state is IDLE; `busy` drops the following cycle.
- `start` while `busy` is ignored. It is not queued.
- `reset` in any state returns the block to reset values on the next edge, with no partial frame completion. The slave re-frames on the next `load`.
- `done` that is already high when WAIT is entered is honoured immediately; its settle delay still applies.
- The divider counts 0..CLKDIV-1. At terminal count it toggles `sclk` and emits a rise or fall strobe. The divider counter is 8 bits wide; the bit counter is 9 bits and saturates at 256.

## Timing
- Accepted `start` at edge 0:
  - `load`, `busy` and `mosi` are valid after edge 1.
  - First `sclk` rise occurs at edge 1+CLKDIV.
  - Each bit occupies 2·CLKDIV cycles.
- LOAD duration is 512·CLKDIV cycles. READ duration is 256·CLKDIV cycles.
- `done`-to-first-read-rise is 2 (sync) + CLKDIV (settle) + CLKDIV cycles.
- `mosi` changes only in cycles where `sclk` falls, never at a rising edge.
- Synchronized `miso` is sampled CLKDIV cycles after the slave's falling-edge update. This is why CLKDIV ≥ 4.

## Structure
- Shared package `invaes_pkg` holds:
  - `spi_state_t` enum: IDLE, LOAD, WAIT, READ, FIN.
  - `BLOCK_BITS`=128 and `LOAD_BITS`=256.
- One sub-module, `spi_clkgen`: the CLKDIV divider producing `sclk`, `rise` and `fall` strobes, with an `en` input. When `en` is low it holds `sclk`=0 and clears its count.
- The FSM, shift registers and synchronizers live in the top module.

## Test plan
- FIPS-197 vector, CLKDIV=4:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, plaintext 69c4e0d86a7b0430d8cdb78070b4c55a. The behavioural slave asserts `done` 50 cycles after `load` falls and returns 00112233445566778899aabbccddeeff.
  - Required: `cyphertext` equals 00112233445566778899aabbccddeeff, `valid` is high for exactly 1 cycle, and `busy`=0 on the next cycle.
- Load bit order:
  - Stimulus: plaintext=1<<127, key=1.
  - Required: `mosi`=1 only during bit 0 and bit 255. Exactly 256 rises occur while `load`=1.
- Read bit order:
  - Stimulus: the slave returns 80000000000000000000000000000001.
  - Required: `cyphertext` equals that value, and no `sclk` edge occurs during WAIT.
- `sclk` shape, CLKDIV=6:
  - Required: every high and low phase is 6 cycles, and the first rise lands at edge 7 after `start`.
- Long wait and ignored start:
  - Stimulus: `done` is delayed 5000 cycles; `start` is pulsed during LOAD and again during WAIT.
  - Required: exactly one `valid` is produced and the captured inputs are unchanged.
- Reset mid-frame:
  - Stimulus: `reset` is asserted after the 100th rise.
  - Required: next cycle `sclk`=0, `load`=0, `busy`=0, `mosi`=0. A following `start` completes correctly.
